// File: rtl/hs_pkg.sv
// Shared definitions for the 4-phase req/ack handshake agents (source and destination).
package hs_pkg;

   // Destination agent FSM states
   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } hs_state_e;

   // Default width of a transferred matrix word
   localparam int HS_DATA_W    = 8;

   // Words per frame: two 16-element operand matrices
   localparam int HS_FRAME_LEN = 32;

endpackage : hs_pkg

// File: rtl/sync_ff_chain.sv
// Single-bit synchroniser: SYNC_STAGES flops in series, all reset to 0.
// Used for sreq on the destination side and for dack on the source side.
module sync_ff_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_chain;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule : sync_ff_chain

// File: rtl/handshake_dst_agent.sv
// Destination-side agent of the 4-phase req/ack handshake.
// Synchronises sreq, captures din once per request, returns dack and
// presents each captured word as a one-cycle dout_valid pulse.
// Optional frame counter enabled by defining HS_DST_FRAME_CNT_EN; without it
// word_cnt and frame_done are tied to 0 and the port list is unchanged.
module handshake_dst_agent
   import hs_pkg::*;
#(
   parameter  int DATA_W      = HS_DATA_W,
   parameter  int SYNC_STAGES = 2,
   parameter  int FRAME_LEN   = HS_FRAME_LEN,
   localparam int CNT_W       = $clog2(FRAME_LEN) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sreq,
   input  logic [DATA_W-1:0] din,
   input  logic              busy,
   output logic              dack,
   output logic              dout_valid,
   output logic [DATA_W-1:0] dout,
   output logic              frame_done,
   output logic [CNT_W-1:0]  word_cnt
);

   logic              w_req_s;
   logic              w_capture;
   hs_state_e         r_state;
   logic              r_dack;
   logic              r_dout_valid;
   logic [DATA_W-1:0] r_dout;

   sync_ff_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sreq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (sreq),
      .o_q   (w_req_s)
   );

   // A word is taken only from idle, with a synchronised request and a ready consumer
   assign w_capture = (r_state == S_IDLE) && w_req_s && !busy;

   // Handshake FSM with registered dack / dout_valid / dout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_dack       <= 1'b0;
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_capture) begin
                  r_state      <= S_ACK;
                  r_dout       <= din;
                  r_dout_valid <= 1'b1;
                  r_dack       <= 1'b1;
               end else begin
                  r_dout_valid <= 1'b0;
               end
            end
            S_ACK: begin
               // Leave only on falling request so one request yields one capture
               r_dout_valid <= 1'b0;
               if (!w_req_s) begin
                  r_state <= S_IDLE;
                  r_dack  <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_dack       <= 1'b0;
               r_dout_valid <= 1'b0;
            end
         endcase
      end
   end

   assign dack       = r_dack;
   assign dout_valid = r_dout_valid;
   assign dout       = r_dout;

`ifdef HS_DST_FRAME_CNT_EN
   logic [CNT_W-1:0] r_word_cnt;
   logic             r_frame_done;

   // Count captures; the FRAME_LEN-th capture wraps the count and flags frame_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_cnt   <= '0;
         r_frame_done <= 1'b0;
      end else if (w_capture) begin
         if (r_word_cnt == CNT_W'(FRAME_LEN - 1)) begin
            r_word_cnt   <= '0;
            r_frame_done <= 1'b1;
         end else begin
            r_word_cnt   <= r_word_cnt + 1'b1;
            r_frame_done <= 1'b0;
         end
      end else begin
         r_frame_done <= 1'b0;
      end
   end

   assign word_cnt   = r_word_cnt;
   assign frame_done = r_frame_done;
`else
   assign word_cnt   = '0;
   assign frame_done = 1'b0;
`endif

endmodule : handshake_dst_agent

// File: tb/tb_handshake_dst_agent.sv
// Bench for handshake_dst_agent: directed latency/back-pressure/reset cases
// plus randomized transfers checked by a queue-based reference model.
module tb_handshake_dst_agent;
   import hs_pkg::*;

   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;
   localparam int FRAME_LEN   = 32;
   localparam int CNT_W       = $clog2(FRAME_LEN) + 1;
   localparam int LAT         = SYNC_STAGES + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sreq;
   logic [DATA_W-1:0] din;
   logic              busy;
   logic              dack;
   logic              dout_valid;
   logic [DATA_W-1:0] dout;
   logic              frame_done;
   logic [CNT_W-1:0]  word_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   logic [DATA_W-1:0] exp_q[$];
   int                mdl_cnt   = 0;
   logic [DATA_W-1:0] last_dout = '0;
   logic              prev_vld  = 1'b0;
   int                fd_cnt    = 0;
   logic [DATA_W-1:0] fd_word   = '0;

   handshake_dst_agent #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FRAME_LEN   (FRAME_LEN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sreq       (sreq),
      .din        (din),
      .busy       (busy),
      .dack       (dack),
      .dout_valid (dout_valid),
      .dout       (dout),
      .frame_done (frame_done),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: every dout_valid must deliver the oldest outstanding word;
   // the frame counter is the number of deliveries modulo FRAME_LEN.
   always @(negedge clk) begin
      if (!rst_n) begin
         mdl_cnt   = 0;
         last_dout = '0;
         prev_vld  = 1'b0;
      end else begin
         if (dout_valid) begin
            chk("valid_b2b", {31'd0, prev_vld}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'd1, 32'd0);
            end else begin
               chk("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
            mdl_cnt++;
`ifdef HS_DST_FRAME_CNT_EN
            chk("frame_done", {31'd0, frame_done}, (mdl_cnt == FRAME_LEN) ? 32'd1 : 32'd0);
            mdl_cnt = mdl_cnt % FRAME_LEN;
            chk("word_cnt", 32'(word_cnt), 32'(mdl_cnt));
`else
            chk("frame_done_off", {31'd0, frame_done}, 32'd0);
            chk("word_cnt_off", 32'(word_cnt), 32'd0);
`endif
            if (frame_done) begin
               fd_cnt++;
               fd_word = dout;
            end
            last_dout = dout;
         end else begin
            chk("dout_hold", {24'd0, dout}, {24'd0, last_dout});
            chk("fd_without_valid", {31'd0, frame_done}, 32'd0);
         end
         prev_vld = dout_valid;
      end
   end

   // One full 4-phase transfer driven as the source agent would
   task automatic xfer(input logic [DATA_W-1:0] d, input bit rb, input int gap);
      int n;
      din  = d;
      sreq = 1'b1;
      exp_q.push_back(d);
      n = 0;
      do begin
         busy = rb ? ($urandom_range(0, 2) == 0) : 1'b0;
         tick();
         n++;
      end while (!dack && n < 100);
      chk("ack_rise_timeout", {31'd0, dack}, 32'd1);
      sreq = 1'b0;
      n = 0;
      do begin
         busy = rb ? ($urandom_range(0, 2) == 0) : 1'b0;
         tick();
         n++;
      end while (dack && n < 100);
      chk("ack_fall_timeout", {31'd0, dack}, 32'd0);
      busy = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      // Reset with request held high and all-ones data
      rst_n = 1'b0;
      sreq  = 1'b1;
      din   = 8'hFF;
      busy  = 1'b0;
      tick();
      tick();
      chk("rst_dack", {31'd0, dack}, 32'd0);
      chk("rst_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      sreq = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      // Single word: rise latency, pulse width, fall latency
      din  = 8'hA5;
      sreq = 1'b1;
      exp_q.push_back(8'hA5);
      n = 0;
      do begin
         tick();
         n++;
      end while (!dout_valid && n < 20);
      chk("lat_rise", 32'(n), 32'(LAT));
      chk("single_dack", {31'd0, dack}, 32'd1);
      chk("single_dout", {24'd0, dout}, 32'h0000_00A5);
      tick();
      chk("single_pulse_width", {31'd0, dout_valid}, 32'd0);
      repeat (5) tick();
      chk("single_dack_held", {31'd0, dack}, 32'd1);
      sreq = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (dack && n < 20);
      chk("lat_fall", 32'(n), 32'(LAT));
      tick();

      // Back-pressure around the request rise
      busy = 1'b1;
      tick();
      tick();
      din  = 8'h3C;
      sreq = 1'b1;
      exp_q.push_back(8'h3C);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("bp_no_dack", {31'd0, dack}, 32'd0);
         chk("bp_no_valid", {31'd0, dout_valid}, 32'd0);
      end
      busy = 1'b0;
      tick();
      chk("bp_release_valid", {31'd0, dout_valid}, 32'd1);
      chk("bp_release_dack", {31'd0, dack}, 32'd1);
      sreq = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (dack && n < 20);
      chk("bp_fall_timeout", {31'd0, dack}, 32'd0);

      // Frame of 32 words 0..31 with random back-pressure and gaps
      do_reset();
      fd_cnt = 0;
      for (int i = 0; i < FRAME_LEN; i++)
         xfer(8'(i), 1'b1, $urandom_range(0, 2));
      tick();
`ifdef HS_DST_FRAME_CNT_EN
      chk("frame_pulses", 32'(fd_cnt), 32'd1);
      chk("frame_word", {24'd0, fd_word}, 32'(FRAME_LEN - 1));
      chk("frame_wrap", 32'(word_cnt), 32'd0);
`else
      chk("frame_pulses_off", 32'(fd_cnt), 32'd0);
      chk("frame_wrap_off", 32'(word_cnt), 32'd0);
`endif
      xfer(8'h77, 1'b0, 0);
`ifdef HS_DST_FRAME_CNT_EN
      chk("word33_cnt", 32'(word_cnt), 32'd1);
`else
      chk("word33_cnt_off", 32'(word_cnt), 32'd0);
`endif

      // Random traffic, including back-to-back requests (gap 0)
      for (int i = 0; i < 40; i++)
         xfer(8'($urandom), ($urandom_range(0, 1) == 1), $urandom_range(0, 3));

      // Reset while in the acknowledge phase with sreq still high
      din  = 8'hC3;
      sreq = 1'b1;
      exp_q.push_back(8'hC3);
      n = 0;
      do begin
         tick();
         n++;
      end while (!dack && n < 20);
      chk("midack_dack", {31'd0, dack}, 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midack_async_dack", {31'd0, dack}, 32'd0);
      chk("midack_async_dout", {24'd0, dout}, 32'd0);
      exp_q.push_back(8'hC3);
      tick();
      tick();
      rst_n = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!dout_valid && n < 20);
      chk("recapture_lat", 32'(n), 32'(LAT));
      chk("recapture_dout", {24'd0, dout}, 32'h0000_00C3);
      sreq = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (dack && n < 20);
      chk("recapture_fall", {31'd0, dack}, 32'd0);
      repeat (3) tick();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_handshake_dst_agent
